// File: rtl/touch_ctrl_pkg.sv
// rtl/touch_ctrl_pkg.sv - Mode and press-state encodings shared by the touch mode controller
package touch_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } press_st_t;

  // Long press takes precedence; the two strobes are never raised together.
  function automatic mode_t next_mode(input mode_t cur, input logic short_p, input logic long_p);
    mode_t nxt;
    nxt = cur;
    if (long_p) begin
      if (cur == MODE_BLINK) nxt = MODE_ON;
      else                   nxt = MODE_BLINK;
    end else if (short_p) begin
      if (cur == MODE_OFF) nxt = MODE_ON;
      else                 nxt = MODE_OFF;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/touch_debounce.sv
// rtl/touch_debounce.sv - Two-flop synchroniser and stability counter for the raw touch level
module touch_debounce
  import touch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic touch_key,
  output logic key_stable
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_key_stable;
  logic [CNT_W-1:0] r_cnt;

  // The counter only advances while the synchronised level disagrees with the accepted one.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_key_stable <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_sync1 <= touch_key;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_key_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_key_stable <= r_sync2;
        r_cnt        <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign key_stable = r_key_stable;

endmodule

// File: rtl/touch_mode_ctrl.sv
// rtl/touch_mode_ctrl.sv - Touch press classifier and OFF/ON/BLINK LED sequencer
// Optional idle auto-off is built when TOUCH_AUTO_OFF_EN is defined.
module touch_mode_ctrl
  import touch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int BLINK_HALF   = 12_500_000
`ifdef TOUCH_AUTO_OFF_EN
  ,
  parameter int AUTO_OFF_CYC = 1_500_000_000
`endif
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       touch_key,
  output logic       led,
  output logic [1:0] mode,
  output logic       short_pulse,
  output logic       long_pulse
);

  localparam int                 HOLD_W    = $clog2(LONG_CYC) + 1;
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(LONG_CYC - 1);
  localparam int                 BLINK_W   = $clog2(BLINK_HALF) + 1;
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_HALF - 1);

  logic               w_key_stable;
  press_st_t          r_state;
  press_st_t          w_state_nxt;
  logic [HOLD_W-1:0]  r_hold;
  logic               w_hold_done;
  logic               w_short_evt;
  logic               w_long_evt;
  logic               r_short_pulse;
  logic               r_long_pulse;
  mode_t              r_mode;
  mode_t              w_mode_nxt;
  logic               r_led;
  logic [BLINK_W-1:0] r_blink_cnt;

  touch_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .touch_key (touch_key),
    .key_stable(w_key_stable)
  );

  assign w_hold_done = (r_hold == HOLD_MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // A release seen on the same cycle the hold count matures still counts as long.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (w_key_stable) w_state_nxt = ST_PRESSED;
      ST_PRESSED: begin
        if (w_hold_done)        w_state_nxt = ST_LONG_HELD;
        else if (!w_key_stable) w_state_nxt = ST_IDLE;
      end
      ST_LONG_HELD: if (!w_key_stable) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_short_evt = 1'b0;
    w_long_evt  = 1'b0;
    if (r_state == ST_PRESSED) begin
      w_long_evt  = w_hold_done;
      w_short_evt = !w_hold_done && !w_key_stable;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hold        <= '0;
      r_short_pulse <= 1'b0;
      r_long_pulse  <= 1'b0;
    end else begin
      r_short_pulse <= w_short_evt;
      r_long_pulse  <= w_long_evt;
      if (r_state != ST_PRESSED) r_hold <= '0;
      else if (!w_hold_done)     r_hold <= r_hold + HOLD_W'(1);
    end
  end

`ifdef TOUCH_AUTO_OFF_EN
  localparam int                IDLE_W   = $clog2(AUTO_OFF_CYC) + 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(AUTO_OFF_CYC - 1);

  logic [IDLE_W-1:0] r_idle;
  logic              w_idle_done;

  assign w_idle_done = (r_mode != MODE_OFF) && (r_idle == IDLE_MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_idle <= '0;
    end else if (r_mode == MODE_OFF || r_short_pulse || r_long_pulse || w_key_stable || w_idle_done) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IDLE_W'(1);
    end
  end

  always_comb begin
    w_mode_nxt = next_mode(r_mode, r_short_pulse, r_long_pulse);
    if (w_idle_done && !r_short_pulse && !r_long_pulse) w_mode_nxt = MODE_OFF;
  end
`else
  always_comb begin
    w_mode_nxt = next_mode(r_mode, r_short_pulse, r_long_pulse);
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_mode <= MODE_ON;
    else            r_mode <= w_mode_nxt;
  end

  // led is decided from the incoming mode so it changes on the same edge as mode.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_led       <= 1'b1;
      r_blink_cnt <= '0;
    end else if (w_mode_nxt != r_mode) begin
      r_led       <= (w_mode_nxt != MODE_OFF);
      r_blink_cnt <= '0;
    end else if (r_mode == MODE_BLINK) begin
      if (r_blink_cnt == BLINK_MAX) begin
        r_led       <= ~r_led;
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end else begin
      r_led       <= (r_mode == MODE_ON);
      r_blink_cnt <= '0;
    end
  end

  assign led         = r_led;
  assign mode        = r_mode;
  assign short_pulse = r_short_pulse;
  assign long_pulse  = r_long_pulse;

endmodule

// File: tb/tb_touch_mode_ctrl.sv
// tb/tb_touch_mode_ctrl.sv - Directed bench for touch_mode_ctrl with small debounce/hold/blink timings
module tb_touch_mode_ctrl;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       touch_key = 1'b0;
  logic       led;
  logic [1:0] mode;
  logic       short_pulse;
  logic       long_pulse;

  int checks = 0;
  int errors = 0;

`ifdef TOUCH_AUTO_OFF_EN
  localparam bit AUTO_OFF = 1'b1;
`else
  localparam bit AUTO_OFF = 1'b0;
`endif

  touch_mode_ctrl #(
    .DEBOUNCE_CYC(4),
    .LONG_CYC    (20),
    .BLINK_HALF  (5)
`ifdef TOUCH_AUTO_OFF_EN
    ,
    .AUTO_OFF_CYC(50)
`endif
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .touch_key  (touch_key),
    .led        (led),
    .mode       (mode),
    .short_pulse(short_pulse),
    .long_pulse (long_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic apply_reset();
    touch_key = 1'b0;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  // Holds the key for hold_cyc cycles, watches for window cycles; pulse times are edge counts from press start.
  task automatic press(input int hold_cyc, input int window,
                       output int n_short, output int n_long, output int t_short, output int t_long);
    n_short = 0; n_long = 0; t_short = -1; t_long = -1;
    touch_key = 1'b1;
    for (int c = 1; c <= window; c++) begin
      @(negedge sys_clk);
      if (short_pulse) begin n_short++; if (t_short < 0) t_short = c; end
      if (long_pulse)  begin n_long++;  if (t_long  < 0) t_long  = c; end
      if (c == hold_cyc) touch_key = 1'b0;
    end
  endtask

  task automatic test_reset();
    int bad_cyc;
    int n_pulse;
    logic [1:0] exp_mode;
    sys_rst_n = 1'b0;
    touch_key = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (led !== 1'b1 || mode !== 2'd1 || short_pulse !== 1'b0 || long_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: led=%b mode=%0d sp=%b lp=%b want led=1 mode=1 sp=0 lp=0",
               led, mode, short_pulse, long_pulse);
    end
    sys_rst_n = 1'b1;
    bad_cyc = -1; n_pulse = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge sys_clk);
      exp_mode = (AUTO_OFF && c >= 50) ? 2'd0 : 2'd1;
      if ((mode !== exp_mode || led !== exp_mode[0]) && bad_cyc < 0) bad_cyc = c;
      if (short_pulse || long_pulse) n_pulse++;
    end
    checks++;
    if (bad_cyc != -1) begin
      errors++;
      $display("FAIL idle_mode: first wrong cycle %0d (mode=%0d led=%b), want none", bad_cyc, mode, led);
    end
    checks++;
    if (n_pulse != 0) begin
      errors++;
      $display("FAIL idle_pulses: got %0d pulses want 0", n_pulse);
    end
  endtask

  task automatic test_glitch();
    int ns, nl, ts, tl;
    apply_reset();
    press(3, 30, ns, nl, ts, tl);
    checks++;
    if (ns != 0 || nl != 0) begin
      errors++;
      $display("FAIL glitch_pulses: short=%0d long=%0d want 0 0", ns, nl);
    end
    checks++;
    if (mode !== 2'd1 || led !== 1'b1) begin
      errors++;
      $display("FAIL glitch_mode: mode=%0d led=%b want 1 1", mode, led);
    end
  endtask

  task automatic test_short();
    int ns, nl, ts, tl;
    apply_reset();
    press(10, 30, ns, nl, ts, tl);
    checks++;
    if (ns != 1 || ts != 17 || nl != 0) begin
      errors++;
      $display("FAIL short1_pulse: n=%0d t=%0d long=%0d want 1 17 0", ns, ts, nl);
    end
    checks++;
    if (mode !== 2'd0 || led !== 1'b0) begin
      errors++;
      $display("FAIL short1_mode: mode=%0d led=%b want 0 0", mode, led);
    end
    press(10, 30, ns, nl, ts, tl);
    checks++;
    if (ns != 1 || ts != 17 || nl != 0) begin
      errors++;
      $display("FAIL short2_pulse: n=%0d t=%0d long=%0d want 1 17 0", ns, ts, nl);
    end
    checks++;
    if (mode !== 2'd1 || led !== 1'b1) begin
      errors++;
      $display("FAIL short2_mode: mode=%0d led=%b want 1 1", mode, led);
    end
    // Shortest press that passes the debouncer
    press(4, 25, ns, nl, ts, tl);
    checks++;
    if (ns != 1 || ts != 11 || mode !== 2'd0) begin
      errors++;
      $display("FAIL short_min: n=%0d t=%0d mode=%0d want 1 11 0", ns, ts, mode);
    end
  endtask

  task automatic test_long();
    int ns, nl, ts, tl, blink_bad;
    logic exp_led;
    apply_reset();
    ns = 0; nl = 0; tl = -1; blink_bad = -1;
    touch_key = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge sys_clk);
      if (short_pulse) ns++;
      if (long_pulse) begin nl++; if (tl < 0) tl = c; end
      if (c >= 28 && c <= 47) begin
        exp_led = (((c - 28) / 5) % 2) == 0;
        if ((led !== exp_led || mode !== 2'd2) && blink_bad < 0) blink_bad = c;
      end
      if (c == 40) touch_key = 1'b0;
    end
    checks++;
    if (nl != 1 || tl != 27) begin
      errors++;
      $display("FAIL long1_pulse: n=%0d t=%0d want 1 27", nl, tl);
    end
    checks++;
    if (ns != 0) begin
      errors++;
      $display("FAIL long1_release: short=%0d want 0", ns);
    end
    checks++;
    if (blink_bad != -1) begin
      errors++;
      $display("FAIL blink_pattern: first wrong cycle %0d, want none", blink_bad);
    end
    press(40, 60, ns, nl, ts, tl);
    checks++;
    if (nl != 1 || tl != 27 || ns != 0) begin
      errors++;
      $display("FAIL long2_pulse: long=%0d t=%0d short=%0d want 1 27 0", nl, tl, ns);
    end
    checks++;
    if (mode !== 2'd1 || led !== 1'b1) begin
      errors++;
      $display("FAIL long2_mode: mode=%0d led=%b want 1 1", mode, led);
    end
  endtask

  task automatic test_long_boundary();
    int ns, nl, ts, tl;
    apply_reset();
    press(19, 40, ns, nl, ts, tl);
    checks++;
    if (ns != 1 || ts != 26 || nl != 0 || mode !== 2'd0) begin
      errors++;
      $display("FAIL edge_short: short=%0d t=%0d long=%0d mode=%0d want 1 26 0 0", ns, ts, nl, mode);
    end
    press(20, 40, ns, nl, ts, tl);
    checks++;
    if (nl != 1 || tl != 27 || ns != 0 || mode !== 2'd2) begin
      errors++;
      $display("FAIL edge_long: long=%0d t=%0d short=%0d mode=%0d want 1 27 0 2", nl, tl, ns, mode);
    end
  endtask

  task automatic test_blink_off_and_reset();
    int ns, nl, ts, tl, bad;
    apply_reset();
    press(40, 60, ns, nl, ts, tl);
    checks++;
    if (mode !== 2'd2) begin
      errors++;
      $display("FAIL b2o_enter: mode=%0d want 2", mode);
    end
    press(10, 30, ns, nl, ts, tl);
    checks++;
    if (ns != 1 || ts != 17 || mode !== 2'd0 || led !== 1'b0) begin
      errors++;
      $display("FAIL b2o_short: n=%0d t=%0d mode=%0d led=%b want 1 17 0 0", ns, ts, mode, led);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      if (led !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL off_led_steady: %0d lit cycles want 0", bad);
    end
    touch_key = 1'b1;
    repeat (15) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (led !== 1'b1 || mode !== 2'd1 || short_pulse !== 1'b0 || long_pulse !== 1'b0) begin
      errors++;
      $display("FAIL midpress_reset: led=%b mode=%0d sp=%b lp=%b want 1 1 0 0",
               led, mode, short_pulse, long_pulse);
    end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    press(10, 30, ns, nl, ts, tl);
    checks++;
    if (ns != 1 || ts != 17 || mode !== 2'd0) begin
      errors++;
      $display("FAIL held_after_reset: n=%0d t=%0d mode=%0d want 1 17 0", ns, ts, mode);
    end
  endtask

  task automatic test_auto_off();
    int t_off, n_pulse, exp_t;
    apply_reset();
    t_off = -1; n_pulse = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge sys_clk);
      if (mode === 2'd0 && t_off < 0) t_off = c;
      if (short_pulse || long_pulse) n_pulse++;
    end
    exp_t = AUTO_OFF ? 50 : -1;
    checks++;
    if (t_off != exp_t) begin
      errors++;
      $display("FAIL auto_off_time: got %0d want %0d", t_off, exp_t);
    end
    checks++;
    if (led !== !AUTO_OFF || n_pulse != 0) begin
      errors++;
      $display("FAIL auto_off_led: led=%b pulses=%0d want led=%b pulses=0", led, n_pulse, !AUTO_OFF);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_short();
    test_long();
    test_long_boundary();
    test_blink_off_and_reset();
    test_auto_off();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/touch_mode_ctrl.md
Name: touch_mode_ctrl

Overview:
- Sequencer between the capacitive touch key pad and the board LED.
- Synchronises and debounces the raw touch input, then classifies each press as short or long.
- Drives a 3-mode LED state machine: OFF, ON, BLINK.
- Replaces the simple edge-toggle LED path; exposes press pulses and current mode to other logic.

Parameters:
- DEBOUNCE_CYC, 500_000, cycles the synchronised input must be stable before it is accepted (10 ms at 50 MHz).
- LONG_CYC, 50_000_000, held-press cycles that classify a long press (1 s).
- BLINK_HALF, 12_500_000, cycles per LED half-period in BLINK mode (250 ms).
- AUTO_OFF_CYC, 1_500_000_000, idle cycles before auto-off (30 s). Used only with the optional feature.

Ports:
- sys_clk, input, 1, system clock, 50 MHz.
- sys_rst_n, input, 1, asynchronous active-low reset.
- touch_key, input, 1, raw touch pad level; 1 = touched; asynchronous.
- led, output, 1, LED drive; 1 = lit.
- mode, output, 2, current mode: 0 = OFF, 1 = ON, 2 = BLINK. Encoding 3 is never driven.
- short_pulse, output, 1, one-cycle strobe on short-press classification.
- long_pulse, output, 1, one-cycle strobe on long-press classification.

Interface decision: one clock, sys_clk. Reset sys_rst_n is asynchronous, active-low.

Behaviour:
Reset values:
- led = 1, mode = ON.
- short_pulse = 0, long_pulse = 0.
- Synchroniser flops = 0, key_stable = 0.
- All counters = 0. Press FSM in IDLE.

Synchroniser and debounce:
- Two-flop synchroniser produces key_sync.
- Debounce counter clears whenever key_sync == key_stable.
- Otherwise it increments. When it reaches DEBOUNCE_CYC-1, key_stable takes key_sync on the next edge and the counter clears.
- Any glitch shorter than DEBOUNCE_CYC cycles never changes key_stable.

Press FSM (IDLE, PRESSED, LONG_HELD):
- IDLE -> PRESSED: on key_stable rising; hold counter cleared.
- PRESSED:
  - Hold counter increments each cycle.
  - If key_stable falls first: short_pulse = 1 for exactly one cycle (the cycle after the fall is seen), then -> IDLE.
  - If hold counter reaches LONG_CYC-1: long_pulse = 1 for one cycle, then -> LONG_HELD.
  - If the fall and the LONG_CYC-1 count land in the same cycle, the press is long.
- LONG_HELD: wait for key_stable low, then -> IDLE. Release from this state emits no pulse.
- Hold counter saturates; it never wraps.

Mode FSM, evaluated on the pulses (updates the cycle after the pulse):
- short press: OFF -> ON, ON -> OFF, BLINK -> OFF.
- long press: OFF -> BLINK, ON -> BLINK, BLINK -> ON.

LED output:
- OFF: led = 0.
- ON: led = 1.
- BLINK: entry clears the blink counter and forces led = 1. led then toggles every BLINK_HALF cycles.
- The blink counter is held at 0 outside BLINK.
- led is registered and tracks mode in the same cycle mode updates.

Other rules:
- Reset mid-press: everything returns to reset values. A key still held after reset release is debounced as a new press.
- Counter widths are sized with $clog2 of the relevant parameter +1.

Optional Feature:
Macro: TOUCH_AUTO_OFF_EN
- Defined:
  - An idle counter runs while mode != OFF. It clears on any short_pulse/long_pulse and whenever key_stable = 1.
  - On reaching AUTO_OFF_CYC-1, mode -> OFF and led = 0 on the next edge. No pulse is emitted.
  - If a pulse lands in the same cycle as the timeout, the pulse wins.
- Undefined: no idle counter; modes persist indefinitely.

Decomposition:
- Package touch_ctrl_pkg holds:
  - mode encodings MODE_OFF/MODE_ON/MODE_BLINK.
  - press-state encodings ST_IDLE/ST_PRESSED/ST_LONG_HELD.
- Sub-module touch_debounce holds synchroniser plus debounce counter.
  - Parameter DEBOUNCE_CYC.
  - Ports sys_clk, sys_rst_n, touch_key, key_stable.
- Press FSM, mode FSM and blink logic stay in the top module.

Test Plan:
All scenarios use DEBOUNCE_CYC=4, LONG_CYC=20, BLINK_HALF=5, AUTO_OFF_CYC=50.
1. Reset, no touch -> led=1, mode=1, no pulses for 100 cycles.
2. touch_key high for 3 cycles only -> key_stable never rises; no pulses; mode stays 1.
3. touch_key high 10 cycles, then low -> one short_pulse after debounced release; mode 1->0; led=0. Repeat press -> mode 0->1, led=1.
4. touch_key high 40 cycles -> long_pulse exactly once at hold count 19; mode -> 2; led toggles every 5 cycles starting at 1; release gives no short_pulse. Second long press -> mode 1, led=1.
5. From BLINK, short press -> mode 0, led=0, blink counter held 0. Assert sys_rst_n low mid-press -> led=1, mode=1, pulses 0.
6. TOUCH_AUTO_OFF_EN defined: mode 1, idle 50 cycles -> mode 0, led=0, no pulse. Undefined: same stimulus -> mode stays 1.
